proc_multiciclo_param: RTL and testbench

Parametrised multicycle 16-bit-instruction processor core: fetch/decode/execute/writeback FSM, parametrised register file and ALU, explicit PC/branch/jump logic. It is the successor to the current board-level processor datapath.
- Instruction memory sits outside the core, behind a req/ack handshake.
- Register/PC debug visibility is exported for the board's 7-segment layer.

---
 rtl/proc_multiciclo_param_if.sv | 12 +
 rtl/proc_multiciclo_param.sv | 120 ++++++++++++
 tb/tb_proc_multiciclo_param.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_multiciclo_param_if.sv
// proc_multiciclo_param_if: instruction-memory req/ack fetch bus between the core and its memory.
interface proc_multiciclo_param_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            imem_ack;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/proc_multiciclo_param.sv
// proc_multiciclo_param: multicycle 16-bit-instruction core (fetch/decode/exec/wb FSM, parametrised regfile/ALU/PC).
module proc_multiciclo_param #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int PC_W   = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    RST_N,
    proc_multiciclo_param_if.master imem,
    input  logic [3:0]              dbg_sel,
    output logic [DATA_W-1:0]       dbg_data,
    output logic [PC_W-1:0]         pc,
    output logic [DATA_W-1:0]       alu_result,
    output logic                    halted,
    output logic [15:0]             retired
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t             r_state, w_next;
    logic [15:0]        r_ir, r_ret;
    logic [PC_W-1:0]    r_pc, w_npc, w_seq, w_br, w_jmp;
    logic [DATA_W-1:0]  r_a, r_b, r_alu, w_alu, w_imm;
    logic               r_eq;
    logic [DATA_W-1:0]  r_regs [1:NREG-1];
    logic [DATA_W-1:0]  w_rf [16];
    logic [3:0]         w_op, w_rd, w_rs, w_rt;
    logic signed [3:0]  w_off;
    logic               w_is_alu, w_is_beq;

    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:8];
    assign w_rs     = r_ir[7:4];
    assign w_rt     = r_ir[3:0];
    assign w_off    = r_ir[3:0];
    assign w_imm    = DATA_W'(r_ir[7:4]);
    assign w_is_alu = w_op <= 4'd10;
    assign w_is_beq = w_op == 4'd11;

    // Full 16-entry read view: r0 and indices beyond NREG read as zero.
    for (genvar g = 0; g < 16; g++) begin : g_rf
        if (g > 0 && g < NREG) begin : g_live
            assign w_rf[g] = r_regs[g];
        end else begin : g_zero
            assign w_rf[g] = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == S_FETCH  ? (imem.imem_ack ? S_DECODE : S_FETCH) :
                 r_state == S_DECODE ? (w_op == 4'hF ? S_HALT : S_EXEC) :
                 r_state == S_EXEC   ? S_WB :
                 r_state == S_WB     ? S_FETCH : S_HALT;
        imem.imem_req  = RST_N && r_state == S_FETCH;
        imem.imem_addr = r_pc;
    end

    always_comb begin
        w_alu = r_alu;
        case (w_op)
            4'd0:    w_alu = r_a + r_b;
            4'd1:    w_alu = r_a - r_b;
            4'd2:    w_alu = r_a & r_b;
            4'd3:    w_alu = r_a | r_b;
            4'd4:    w_alu = r_a ^ r_b;
            4'd5:    w_alu = DATA_W'(r_a < r_b);
            4'd6:    w_alu = r_b + w_imm;
            4'd7:    w_alu = r_b - w_imm;
            4'd8:    w_alu = r_b & w_imm;
            4'd9:    w_alu = r_b | w_imm;
            4'd10:   w_alu = r_b << r_ir[7:4];
            default: w_alu = r_alu;
        endcase
    end

    assign w_seq = r_pc + PC_W'(1);
    assign w_br  = r_pc + PC_W'(1) + PC_W'(w_off);
    assign w_jmp = PC_W'(r_ir[11:0]);
    assign w_npc = w_is_beq ? (r_eq ? w_br : w_seq) : w_op == 4'd12 ? w_jmp : w_seq;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_ir  <= '0;
            r_pc  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_alu <= '0;
            r_eq  <= 1'b0;
            r_ret <= '0;
            for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            if (r_state == S_FETCH && imem.imem_ack) r_ir <= imem.imem_rdata;
            if (r_state == S_DECODE) begin
                r_a <= w_is_beq ? w_rf[w_rd] : w_rf[w_rs];
                r_b <= w_is_beq ? w_rf[w_rs] : w_rf[w_rt];
                if (w_op == 4'hF) r_ret <= r_ret + 16'd1;
            end
            if (r_state == S_EXEC) begin
                r_alu <= w_alu;
                r_eq  <= r_a == r_b;
            end
            if (r_state == S_WB) begin
                r_pc  <= w_npc;
                r_ret <= r_ret + 16'd1;
                for (int i = 1; i < NREG; i++)
                    if (w_is_alu && w_rd == i[3:0]) r_regs[i] <= r_alu;
            end
        end
    end

    assign dbg_data   = w_rf[dbg_sel];
    assign pc         = r_pc;
    assign alu_result = r_alu;
    assign halted     = r_state == S_HALT;
    assign retired    = r_ret;
endmodule

// File: tb/tb_proc_multiciclo_param.sv
// tb_proc_multiciclo_param: random and directed programs, ISA-level reference model, retirement scoreboard.
module tb_proc_multiciclo_param;
    localparam int DW = 8;
    localparam int NR = 12;
    localparam int PW = 8;
    localparam int DM = (1 << DW) - 1;
    localparam int PM = (1 << PW) - 1;

    typedef struct {int pc; int ret; int halt; int alu;} exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] dbg_sel;
    logic [DW-1:0] dbg_data, alu_result;
    logic [PW-1:0] pc;
    logic halted;
    logic [15:0] retired;

    logic [15:0] mem [256];
    logic [15:0] prog [$];
    int lat, wcnt;
    logic spur;
    exp_t q [$];
    int n_tests, n_fail;
    int m_reg [16];
    int m_pc, m_alu, m_ret, m_halt;

    always #5 clk = ~clk;

    proc_multiciclo_param_if #(.PC_W(PW)) bus ();

    proc_multiciclo_param #(.DATA_W(DW), .NREG(NR), .PC_W(PW)) dut (
        .CLOCK_50(clk), .RST_N(rst_n), .imem(bus), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .pc(pc), .alu_result(alu_result), .halted(halted), .retired(retired)
    );

    // Memory: ack once the request has waited lat cycles; spur forces an unsolicited ack.
    always_comb begin
        bus.imem_ack   = (bus.imem_req && wcnt >= lat) || spur;
        bus.imem_rdata = spur ? 16'h0312 : mem[bus.imem_addr];
    end

    always @(posedge clk) wcnt <= (bus.imem_req && !bus.imem_ack) ? wcnt + 1 : 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        int last;
        exp_t e;
        last = 0;
        forever begin
            @(negedge clk);
            if (rst_n && int'(retired) != last) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got retired=%0d, expected no retirement", retired);
                end else begin
                    e = q.pop_front();
                    check("sb_retired", retired, e.ret);
                    check("sb_pc", pc, e.pc);
                    check("sb_halted", halted, e.halt);
                    check("sb_alu", alu_result, e.alu);
                end
            end
            last = int'(retired);
        end
    end

    function automatic int rv(input int i);
        return (i == 0 || i >= NR) ? 0 : m_reg[i];
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_pc = 0; m_alu = 0; m_ret = 0; m_halt = 0;
    endtask

    task automatic model_step;
        int ir, op, rd, rs, rt, a, b, r, npc, off;
        exp_t e;
        ir = int'(mem[m_pc]);
        op = ir >> 12; rd = (ir >> 8) & 15; rs = (ir >> 4) & 15; rt = ir & 15;
        a = rv(rs); b = rv(rt); r = 0;
        npc = (m_pc + 1) & PM;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a < b) ? 1 : 0;
            6: r = b + rs;
            7: r = b - rs;
            8: r = b & rs;
            9: r = b | rs;
            10: r = b << rs;
            11: begin
                off = rt >= 8 ? rt - 16 : rt;
                if (rv(rd) == rv(rs)) npc = (m_pc + 1 + off) & PM;
            end
            12: npc = (ir & 'hFFF) & PM;
            15: m_halt = 1;
            default: ;
        endcase
        if (op <= 10) begin
            m_alu = r & DM;
            if (rd != 0 && rd < NR) m_reg[rd] = m_alu;
        end
        if (m_halt == 0) m_pc = npc;
        m_ret = (m_ret + 1) & 'hFFFF;
        e.pc = m_pc; e.ret = m_ret; e.halt = m_halt; e.alu = m_alu;
        q.push_back(e);
    endtask

    task automatic model_run;
        int s;
        s = 0;
        while (m_halt == 0 && s < 300) begin
            model_step();
            s++;
        end
    endtask

    task automatic load_prog;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        spur = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", bus.imem_req, 0);
        check("rst_pc", pc, 0);
        check("rst_retired", retired, 0);
        check("rst_halted", halted, 0);
        check("rst_alu", alu_result, 0);
        spur = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_req", bus.imem_req, 1);
        check("rel_addr", bus.imem_addr, 0);
    endtask

    task automatic wait_done;
        int b;
        b = 0;
        while (q.size() != 0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        check("drain_left", q.size(), 0);
    endtask

    task automatic end_checks;
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            check($sformatf("reg%0d", i), dbg_data, rv(i));
        end
        check("end_halted", halted, m_halt);
        check("end_pc", pc, m_pc);
        check("end_req", bus.imem_req, 0);
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        check("spur_pc", pc, m_pc);
        check("spur_retired", retired, m_ret);
        check("spur_halted", halted, 1);
    endtask

    task automatic run_prog(input int l, input int exp_req, input int exp_ret);
        int n, rq;
        lat = l;
        do_reset();
        model_reset();
        model_run();
        if (exp_req >= 0) begin
            n = 0; rq = 0;
            while (retired == 16'd0 && n < 40) begin
                if (bus.imem_req && bus.imem_addr == '0) rq++;
                @(negedge clk);
                n++;
            end
            check("req_cycles", rq, exp_req);
            check("retire_cycle", n, exp_ret);
        end
        wait_done();
        end_checks();
    endtask

    task automatic gen_random;
        int op, f;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        for (int a = 0; a < 6; a++) mem[a] = 16'((9 << 12) | ((a + 1) << 8) | ($urandom_range(0, 15) << 4));
        for (int a = 6; a < 26; a++) begin
            op = $urandom_range(0, 14);
            f = $urandom & 'hFFF;
            if (op == 11) f = (f & 'hFF0) | $urandom_range(0, 7);
            if (op == 12) f = a + 1 + $urandom_range(0, 3);
            mem[a] = 16'((op << 12) | f);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int b;
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; spur = 1'b0; lat = 0; dbg_sel = 4'd0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        prog = '{16'h6150, 16'h6230, 16'h0312, 16'hF000};
        load_prog();
        run_prog(0, 1, 4);
        prog = '{16'h6150, 16'hF000};
        load_prog();
        run_prog(2, 3, 6);
        prog = '{16'h6150, 16'h6250, 16'hC004, 16'h6260, 16'hB12E, 16'hF000};
        load_prog();
        run_prog(1, -1, -1);
        prog = '{16'hB101, 16'hF000, 16'hC0FF};
        load_prog();
        mem[255] = 16'h6110;
        run_prog(0, -1, -1);
        prog = '{16'h7211, 16'h6410, 16'h5324, 16'hA5F2, 16'h6050, 16'h6D50, 16'hF000};
        load_prog();
        run_prog(3, -1, -1);
        prog = '{16'h6140, 16'h6230, 16'h0312, 16'hF000};
        load_prog();
        lat = 0;
        do_reset();
        model_reset();
        model_step();
        model_step();
        b = 0;
        while (retired != 16'd2 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("mid_reach", retired, 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_req", bus.imem_req, 0);
        check("mid_pc", pc, 0);
        check("mid_retired", retired, 0);
        dbg_sel = 4'd3;
        #1;
        check("mid_r3", dbg_data, 0);
        dbg_sel = 4'd1;
        #1;
        check("mid_r1", dbg_data, 0);
        check("mid_queue", q.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_addr", bus.imem_addr, 0);
        model_reset();
        model_run();
        wait_done();
        end_checks();
        for (int k = 0; k < 6; k++) begin
            gen_random();
            run_prog($urandom_range(0, 3), -1, -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
